aes128_stream_core: RTL and testbench
=====================================

# aes128_stream_core

Iterative AES-128 encryption core with a parametrised beat width and valid/ready streaming on both sides. It replaces the fixed byte-serial, fully unrolled encryption top with a single round datapath reused for ten rounds. It also adds input and output back-pressure and an option to reuse the previously loaded key. It sits between the byte/word host interface and downstream ciphertext consumers.

## Interface
- DATA_W, 8, beat width in bits for plaintext, key and ciphertext. Legal values are 8, 32 and 128; any other value fails elaboration.
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  current input beat valid
- in_ready  output  1  core accepts an input beat this cycle
- in_data  input  DATA_W  plaintext beat
- in_key  input  DATA_W  key beat; ignored when the block's key_reuse is set
- key_reuse  input  1  sampled on the first beat of a block; 1 = encrypt with the stored key
- out_valid  output  1  ciphertext beat valid
- out_ready  input  1  consumer accepts ciphertext beat
- out_data  output  DATA_W  ciphertext beat
- busy  output  1  high in ROUND and UNLOAD

## Operation
- N = 128/DATA_W beats per block. Beat 0 carries bits [127 -: DATA_W], i.e. FIPS-197 byte 0 first. The same ordering applies to in_data, in_key and out_data.
- States: LOAD, ROUND, UNLOAD.
- LOAD
  - in_ready=1. A beat transfers when in_valid&in_ready.
  - The beat counter advances 0..N-1 only on a transfer.
  - key_reuse is latched on beat 0.
  - Every transfer writes in_data into the state register. If the latched reuse flag is 0, it also writes in_key into the key register and the stored-key register.
  - The transfer of beat N-1 moves the FSM to ROUND with rnd=0.
- ROUND, rnd=0: state <= state ^ K0. K0 is the stored key; with key_reuse=1 it is the key from the last non-reuse block.
- ROUND, rnd=1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ Kr.
- ROUND, rnd=10: same as rnd 1..9 but without MixColumns.
- Round keys are expanded on the fly in the same cycle: Kr = expand(Kr-1, Rcon[r]). Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. The working key register is updated each round; the stored key is never modified by rounds.
- After rnd=10 the FSM moves to UNLOAD with the beat counter at 0.
- UNLOAD
  - out_valid=1 and out_data = beat counter's slice of state.
  - The counter advances on out_valid&out_ready.
  - The transfer of beat N-1 returns the FSM to LOAD.
- Back-pressure
  - in_valid low mid-block holds the counter; partial blocks are retained indefinitely.
  - out_ready low holds out_data stable.
- Reset (asserted at any time, including mid-block or mid-round)
  - State, key, stored key, counters and FSM are cleared; FSM goes to LOAD.
  - The stored key becomes all-zero. A key_reuse block before any key load therefore encrypts under the all-zero key.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0.
- in_ready is a pure decode of FSM==LOAD; there is no combinational path from in_valid.
- out_valid is a pure decode of FSM==UNLOAD.
- Latency
  - The last input beat transfers at edge t.
  - Round 0 result is registered at t+1; round 10 result at t+11.
  - out_valid is high in the cycle after edge t+11. If out_ready is held high, beat N-1 transfers at edge t+11+N.
- in_ready is high again in the cycle after the final output transfer. There is no overlap of load and unload.
- Throughput with no back-pressure: 2N+11 cycles per block. That is 43 cycles for DATA_W=8, 19 for 32 and 13 for 128.
- busy rises the cycle after the last input transfer and falls the cycle after the last output transfer.

## Test plan
- FIPS-197 C.1, DATA_W=8
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: ct 69c4e0d86a7b0430d8cdb78070b4c55a, first out beat 0x69, out_valid exactly 11 cycles after the last input edge.
- FIPS-197 B, DATA_W=32 and DATA_W=128
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: ct 3925841d02dc09fbdc118597196a0b32. Beats are 3925841d,02dc09fb,dc118597,196a0b32 for DATA_W=32.
- Key reuse
  - Stimulus: C.1 block, then pt 3243f6a8885a308d313198a2e0370734 with key_reuse=1 and in_key driven to garbage.
  - Required: output equals AES(000102..0f, that pt). in_key must have no effect.
- Back-pressure
  - Stimulus: random in_valid/out_ready gaps of 0-5 cycles on C.1.
  - Required: identical ciphertext; out_data is stable while out_valid&!out_ready; no beat is duplicated or dropped.
- Reset mid-operation
  - Stimulus: assert rst asynchronously mid-load, then again at rnd=5.
  - Required: outputs return immediately to reset values. A following full C.1 block yields the correct ct.
- Zero key default
  - Stimulus: after reset, send pt 0 with key_reuse=1.
  - Required: ct 66e94bd4ef8a2c3b884cfa59ca342b2e.

Source files
------------

// File: rtl/aes128_stream_core_if.sv
// aes128_stream_core_if: valid/ready bundle for the AES-128 stream core.
// Input side: in_valid/in_ready, in_data, in_key, key_reuse.
// Output side: out_valid/out_ready, out_data; busy status.
interface aes128_stream_core_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_key;
  logic              key_reuse;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, in_key,
    output key_reuse, out_ready,
    input  in_ready, out_valid,
    input  out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_key,
    input  key_reuse, out_ready,
    output in_ready, out_valid,
    output out_data, busy
  );
endinterface

// File: rtl/aes128_stream_core.sv
// aes128_stream_core: iterative AES-128 encryptor, one round per cycle.
// Ports: clk, rst (async, active high), bus (slave side of the
// stream interface: plaintext/key beats in, ciphertext beats out).
module aes128_stream_core #(
  parameter int DATA_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  aes128_stream_core_if.slave bus
);

  localparam int N  = 128 / DATA_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (DATA_W != 8 && DATA_W != 32 && DATA_W != 128) begin : g_bad_w
    $error("aes128_stream_core: DATA_W must be 8, 32 or 128");
  end

  typedef enum logic [1:0] {
    LOAD,
    ROUND,
    UNLOAD
  } fsm_t;

  fsm_t            fsm_q;
  logic [127:0]    st_q;
  logic [127:0]    key_q;
  logic [127:0]    skey_q;
  logic            reuse_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      rnd_q;

  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] a1, a2, a3, a4, a5, a6, a7;
    a1 = xt(a);
    a2 = xt(a1);
    a3 = xt(a2);
    a4 = xt(a3);
    a5 = xt(a4);
    a6 = xt(a5);
    a7 = xt(a6);
    return (b[0] ? a  : 8'h00) ^
           (b[1] ? a1 : 8'h00) ^
           (b[2] ? a2 : 8'h00) ^
           (b[3] ? a3 : 8'h00) ^
           (b[4] ? a4 : 8'h00) ^
           (b[5] ? a5 : 8'h00) ^
           (b[6] ? a6 : 8'h00) ^
           (b[7] ? a7 : 8'h00);
  endfunction

  // S-box as GF(2^8) inverse (a^254, 0 maps to 0) plus affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] a2, a3, a6, a12, a15, a30;
    logic [7:0] a60, a120, a240, a252, v;
    a2   = gm(a, a);
    a3   = gm(a2, a);
    a6   = gm(a3, a3);
    a12  = gm(a6, a6);
    a15  = gm(a12, a3);
    a30  = gm(a15, a15);
    a60  = gm(a30, a30);
    a120 = gm(a60, a60);
    a240 = gm(a120, a120);
    a252 = gm(a240, a12);
    v    = gm(a252, a2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^
           {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] kexp(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] t, w0, w1, w2, w3;
    t  = subw({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] mix(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Round datapath: byte i of the block is st_q[127-8i -: 8],
  // column-major as in FIPS-197.
  logic [7:0]   sb_o [16];
  logic [7:0]   sr   [16];
  logic [127:0] sr_w;
  logic [127:0] mc_w;
  logic [127:0] k_nx;
  logic [127:0] rnd_d;

  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign sb_o[i] = sbox(st_q[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb_o[4*((c+r)%4)+r];
    end
    assign sr_w[127-32*c -: 32] =
      {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
    assign mc_w[127-32*c -: 32] =
      mix({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
  end

  assign k_nx  = kexp(key_q, rcon(rnd_q));
  assign rnd_d = ((rnd_q == 4'd10) ? sr_w : mc_w) ^ k_nx;

  // Beat slice offset; beat 0 is the most significant slice.
  logic [6:0] off;
  logic       reuse_eff;

  assign off       = 7'(cnt_q) * 7'(DATA_W);
  assign reuse_eff = (cnt_q == '0) ? bus.key_reuse : reuse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= LOAD;
      st_q    <= '0;
      key_q   <= '0;
      skey_q  <= '0;
      reuse_q <= 1'b0;
      cnt_q   <= '0;
      rnd_q   <= '0;
    end else begin
      unique case (fsm_q)
        LOAD: begin
          if (bus.in_valid) begin
            st_q[7'd127 - off -: DATA_W] <= bus.in_data;
            if (!reuse_eff) begin
              key_q[7'd127 - off -: DATA_W]  <= bus.in_key;
              skey_q[7'd127 - off -: DATA_W] <= bus.in_key;
            end
            if (cnt_q == '0) reuse_q <= bus.key_reuse;
            if (cnt_q == LAST) begin
              cnt_q <= '0;
              rnd_q <= '0;
              fsm_q <= ROUND;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ROUND: begin
          // Round 0 restarts the schedule from the stored key, so
          // a reuse block never sees the previous block's K10.
          if (rnd_q == 4'd0) begin
            st_q  <= st_q ^ skey_q;
            key_q <= skey_q;
          end else begin
            st_q  <= rnd_d;
            key_q <= k_nx;
          end
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd10) begin
            cnt_q <= '0;
            fsm_q <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (bus.out_ready) begin
            if (cnt_q == LAST) begin
              cnt_q <= '0;
              fsm_q <= LOAD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: fsm_q <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (fsm_q == LOAD);
  assign bus.out_valid = (fsm_q == UNLOAD);
  assign bus.busy      = (fsm_q != LOAD);
  assign bus.out_data  = (fsm_q == UNLOAD) ?
                         st_q[7'd127 - off -: DATA_W] : '0;

endmodule

// File: tb/tb_aes128_stream_core.sv
// tb_aes128_stream_core: random and FIPS-197 vectors against a
// byte-level AES model; back-pressure, key reuse and reset cases.
module tb_aes128_stream_core;

  localparam int DATA_W = 8;
  localparam int N      = 128 / DATA_W;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           cyc = 0;
  int           t_last = 0;
  int           n_err = 0;
  int           n_chk = 0;
  logic [7:0]   sb [256];
  logic [127:0] mkey;

  aes128_stream_core_if #(.DATA_W(DATA_W)) bus ();

  aes128_stream_core #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction

  // S-box by walking generator 3 and its inverse together.
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key,
                                           input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] v;
    logic [31:0]  x;
    v = key;
    for (int i = 0; i < 4; i++) begin
      w[i] = v[127:96];
      v = v << 32;
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]}
            ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ x;
    end
    v = pt;
    for (int i = 0; i < 16; i++) begin
      s[i] = v[127:120];
      v = v << 8;
    end
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++)
            s[4*c+j] = t[4*((c+j)%4)+j];
        if (r < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1];
            a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        x = w[4*r+c];
        for (int j = 0; j < 4; j++) begin
          s[4*c+j] = s[4*c+j] ^ x[31:24];
          x = x << 8;
        end
      end
    end
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], s[i]};
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] sl(input logic [127:0] v,
                                           input int i);
    return DATA_W'(v >> (128 - DATA_W * (i + 1)));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_block(input logic [127:0] pt,
                            input logic [127:0] key,
                            input logic reuse, input int gmax,
                            input int nb);
    int n;
    for (int i = 0; i < nb; i++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, gmax)) @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = sl(pt, i);
      bus.in_key    = sl(key, i);
      bus.key_reuse = (i == 0) ? reuse : 1'($urandom);
      n = 0;
      while (!bus.in_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) begin
        chk("in_ready_timeout", 128'(bus.in_ready), 128'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = DATA_W'(rnd128());
    bus.in_key   = DATA_W'(rnd128());
    t_last = cyc;
  endtask

  task automatic recv_block(input logic [127:0] exp, input int gmax,
                            output logic [127:0] got,
                            output int lat);
    int n;
    got = '0;
    lat = -1;
    n = 0;
    while (!bus.out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      chk("out_valid_timeout", 128'(bus.out_valid), 128'd1);
      return;
    end
    lat = cyc - t_last;
    for (int i = 0; i < N; i++) begin
      bus.out_ready = 1'b0;
      repeat ($urandom_range(0, gmax)) begin
        @(negedge clk);
        chk("hold", 128'({bus.out_valid, bus.out_data}),
            128'({1'b1, sl(exp, i)}));
      end
      bus.out_ready = 1'b1;
      chk("beat_valid", 128'(bus.out_valid), 128'd1);
      got = (got << DATA_W) | 128'(bus.out_data);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("after_unload", 128'({bus.out_valid, bus.in_ready, bus.busy}),
        128'(3'b010));
  endtask

  task automatic xfer(input string tag, input logic [127:0] pt,
                      input logic [127:0] key, input logic reuse,
                      input int gi, input int go,
                      output logic [127:0] got);
    logic [127:0] exp;
    int lat;
    exp = aes_ref(reuse ? mkey : key, pt);
    if (!reuse) mkey = key;
    send_block(pt, key, reuse, gi, N);
    chk({tag, "_busy"}, 128'(bus.busy), 128'd1);
    recv_block(exp, go, got, lat);
    chk({tag, "_lat"}, 128'(lat), 128'd11);
    chk({tag, "_ct"}, got, exp);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_rst_out"},
        128'({bus.in_ready, bus.out_valid, bus.busy, bus.out_data}),
        128'({1'b1, 1'b0, 1'b0, {DATA_W{1'b0}}}));
    mkey = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [127:0] got;

  initial begin
    build_sbox();
    mkey          = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.key_reuse = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data",  128'(bus.out_data),  128'd0);
    chk("rst_busy",      128'(bus.busy),      128'd0);
    rst = 1'b0;
    @(negedge clk);

    xfer("zero", '0, rnd128(), 1'b1, 0, 0, got);
    chk("zero_const", got, CZ);

    xfer("c1", P1, K1, 1'b0, 0, 0, got);
    chk("c1_const", got, C1);
    chk("c1_beat0", 128'(sl(got, 0)), 128'(sl(C1, 0)));

    xfer("fipsb", P2, K2, 1'b0, 0, 0, got);
    chk("fipsb_const", got, C2);

    xfer("pre_reuse", P1, K1, 1'b0, 0, 0, got);
    xfer("reuse1", P2, rnd128(), 1'b1, 0, 0, got);
    xfer("reuse2", P1, rnd128(), 1'b1, 1, 1, got);
    chk("reuse2_const", got, C1);

    for (int k = 0; k < 4; k++) begin
      xfer("bp", P1, K1, 1'b0, 5, 5, got);
      chk("bp_const", got, C1);
    end

    for (int k = 0; k < 12; k++)
      xfer("rand", rnd128(), rnd128(), 1'($urandom_range(0, 2) == 0),
           $urandom_range(0, 2), $urandom_range(0, 2), got);

    send_block(P2, K2, 1'b0, 0, N / 2);
    async_reset("mid_load");

    send_block(P2, K2, 1'b0, 0, N);
    repeat (5) @(negedge clk);
    async_reset("mid_round");

    xfer("post_rst", P1, K1, 1'b0, 0, 0, got);
    chk("post_rst_const", got, C1);

    async_reset("clr_key");
    xfer("zero2", '0, rnd128(), 1'b1, 2, 2, got);
    chk("zero2_const", got, CZ);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
